// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter merging NUM_REQ valid/ready sources into one registered output slice.
// Define HANDSHAKE_RR_ARBITER_LOCK_EN to add i_last and hold the grant for multi-beat packets.
module handshake_rr_arbiter #(
    parameter int VALUE_BITS = 8,
    parameter int NUM_REQ    = 4,
    parameter int ID_BITS    = $clog2(NUM_REQ)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ*VALUE_BITS-1:0] i_value,
    input  logic [NUM_REQ-1:0]            i_valid,
    output logic [NUM_REQ-1:0]            o_ready,
    output logic [VALUE_BITS-1:0]         o_value,
    output logic [ID_BITS-1:0]            o_id,
    output logic                          o_valid,
    input  logic                          i_ready
`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
    ,
    input  logic [NUM_REQ-1:0]            i_last
`endif
);

    logic [ID_BITS-1:0]    ptr_q, ptr_d;
    logic                  o_valid_q, o_valid_d;
    logic [VALUE_BITS-1:0] o_value_q, o_value_d;
    logic [ID_BITS-1:0]    o_id_q, o_id_d;
`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
    logic                  lock_q, lock_d;
`endif

    logic [VALUE_BITS-1:0] req_value [NUM_REQ];
    logic                  grant_found;
    logic [ID_BITS-1:0]    grant_id;
    logic [ID_BITS-1:0]    idx_id;
    int                    idx;
    logic                  load_en;
    logic                  in_xfer;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_req_value
        assign req_value[k] = i_value[k*VALUE_BITS +: VALUE_BITS];
    end

    // Walk from farthest to nearest so the nearest valid requester after ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        idx_id      = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_id = ID_BITS'(idx);
            if (i_valid[idx_id]) begin
                grant_found = 1'b1;
                grant_id    = idx_id;
            end
        end
`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
        // ptr still names the locked requester, since a transfer always moves ptr to its source.
        if (lock_q) begin
            grant_found = i_valid[ptr_q];
            grant_id    = ptr_q;
        end
`endif
    end

    assign load_en = !o_valid_q | i_ready;
    assign in_xfer = load_en & grant_found & !reset;

    always_comb begin
        o_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            o_ready[k] = in_xfer & (grant_id == ID_BITS'(k));
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        o_valid_d = o_valid_q;
        o_value_d = o_value_q;
        o_id_d    = o_id_q;
`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
        lock_d    = lock_q;
`endif
        if (in_xfer) begin
            o_valid_d = 1'b1;
            o_value_d = req_value[grant_id];
            o_id_d    = grant_id;
            ptr_d     = grant_id;
`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
            lock_d    = !i_last[grant_id];
`endif
        end else if (o_valid_q && i_ready) begin
            o_valid_d = 1'b0;
            o_value_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q     <= ID_BITS'(NUM_REQ - 1);
            o_valid_q <= 1'b0;
            o_value_q <= '0;
            o_id_q    <= '0;
`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
            lock_q    <= 1'b0;
`endif
        end else begin
            ptr_q     <= ptr_d;
            o_valid_q <= o_valid_d;
            o_value_q <= o_value_d;
            o_id_q    <= o_id_d;
`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
            lock_q    <= lock_d;
`endif
        end
    end

    assign o_valid = o_valid_q;
    assign o_value = o_value_q;
    assign o_id    = o_id_q;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed and randomized bench for handshake_rr_arbiter against a round-robin reference model.
module tb_handshake_rr_arbiter;
    localparam int VB = 8;
    localparam int N  = 4;
    localparam int IB = 2;
`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic [N*VB-1:0] i_value;
    logic [N-1:0]    i_valid;
    logic [N-1:0]    o_ready;
    logic [VB-1:0]   o_value;
    logic [IB-1:0]   o_id;
    logic            o_valid;
    logic            i_ready;
`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
    logic [N-1:0]    i_last;
`endif

    handshake_rr_arbiter #(.VALUE_BITS(VB), .NUM_REQ(N)) dut (
        .clock   (clock),
        .reset   (reset),
        .i_value (i_value),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_value (o_value),
        .o_id    (o_id),
        .o_valid (o_valid),
        .i_ready (i_ready)
`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
        ,
        .i_last  (i_last)
`endif
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference state: who was granted last, what the output slice holds, packet lock.
    int            m_ptr;
    bit            m_valid;
    logic [VB-1:0] m_val;
    int            m_id;
    bit            m_lock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = N - 1;
        m_valid = 1'b0;
        m_val   = '0;
        m_id    = 0;
        m_lock  = 1'b0;
    endtask

    function automatic int m_grant(input logic [N-1:0] v);
        if (m_lock) return v[m_ptr] ? m_ptr : -1;
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    // Entered just after a falling edge; leaves just after the next falling edge.
    task automatic cycle(input logic [N-1:0] v, input logic [N*VB-1:0] d, input logic rdy,
                         input logic [N-1:0] last, input logic rst);
        int           g;
        logic [N-1:0] er;
        bit           ld;
        chk("o_valid", o_valid, m_valid);
        chk("o_value", o_value, m_val);
        chk("o_id", o_id, m_id);
        i_valid = v;
        i_value = d;
        i_ready = rdy;
        reset   = rst;
`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
        i_last  = last;
`endif
        #1;
        ld = !m_valid || rdy;
        g  = m_grant(v);
        er = '0;
        if (!rst && ld && g >= 0) er[g] = 1'b1;
        chk("o_ready", o_ready, er);
        @(posedge clock);
        if (rst) begin
            model_reset();
        end else if (er != '0) begin
            m_val   = d[g*VB +: VB];
            m_id    = g;
            m_valid = 1'b1;
            m_ptr   = g;
            m_lock  = LOCK && !last[g];
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
            m_val   = '0;
        end
        @(negedge clock);
    endtask

    initial begin
        int exp_seq [6];
        logic [N*VB-1:0] all_d;
        exp_seq = '{0, 1, 2, 3, 0, 1};
        all_d   = {8'h44, 8'h33, 8'h22, 8'h11};
        reset = 1'b1; i_valid = '0; i_value = '0; i_ready = 1'b0;
`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
        i_last = '0;
`endif
        @(posedge clock);
        @(negedge clock);
        model_reset();

        // Idle after reset
        for (int i = 0; i < 5; i++) cycle('0, '0, 1'b1, '0, 1'b0);
        chk("idle_valid", o_valid, 1'b0);

        // Single requester
        cycle(4'b0001, {24'h0, 8'hA5}, 1'b1, '1, 1'b0);
        chk("a5_value", o_value, 8'hA5);
        chk("a5_id", o_id, 0);
        chk("a5_valid", o_valid, 1'b1);

        // Full rotation from a fresh pointer
        cycle('0, '0, 1'b1, '0, 1'b1);
        for (int j = 0; j < 6; j++) begin
            cycle(4'b1111, all_d, 1'b1, '1, 1'b0);
            chk("rr_id", o_id, exp_seq[j]);
            chk("rr_valid", o_valid, 1'b1);
        end

        // Backpressure hold
        cycle('0, '0, 1'b1, '0, 1'b1);
        cycle(4'b0110, all_d, 1'b1, '1, 1'b0);
        for (int j = 0; j < 4; j++) begin
            cycle(4'b0110, all_d, 1'b0, '1, 1'b0);
            chk("hold_id", o_id, 1);
            chk("hold_value", o_value, 8'h22);
        end
        cycle(4'b0110, all_d, 1'b1, '1, 1'b0);
        chk("after_hold_id", o_id, 2);

        // Reset while a beat is stalled
        cycle(4'b0001, all_d, 1'b0, '1, 1'b0);
        cycle('0, '0, 1'b0, '0, 1'b1);
        chk("rst_drop_valid", o_valid, 1'b0);
        cycle(4'b1000, all_d, 1'b1, '1, 1'b0);
        chk("rst_first_id", o_id, 3);
        cycle(4'b1111, all_d, 1'b1, '1, 1'b0);
        chk("rst_wrap_id", o_id, 0);

`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
        // Three-beat packet from requester 2
        cycle('0, '0, 1'b1, '0, 1'b1);
        cycle(4'b0010, all_d, 1'b1, '1, 1'b0);
        cycle(4'b1111, all_d, 1'b1, 4'b0000, 1'b0);
        chk("lock_id0", o_id, 2);
        cycle(4'b1111, all_d, 1'b1, 4'b0000, 1'b0);
        chk("lock_id1", o_id, 2);
        cycle(4'b1111, all_d, 1'b1, 4'b0100, 1'b0);
        chk("lock_id2", o_id, 2);
        cycle(4'b1111, all_d, 1'b1, 4'b0000, 1'b0);
        chk("lock_id3", o_id, 3);
`endif

        // Randomized traffic
        for (int j = 0; j < 400; j++) begin
            logic [N-1:0]    rv;
            logic [N*VB-1:0] rd;
            logic            rr;
            logic [N-1:0]    rl;
            logic            rs;
            rv = N'($urandom);
            rd = {$urandom, $urandom};
            rr = ($urandom_range(0, 9) < 7);
            rl = N'($urandom);
            rs = ($urandom_range(0, 49) == 0);
            cycle(rv, rd, rr, rl, rs);
        end
        cycle('0, '0, 1'b1, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
